// File: rtl/idma_xif_multich_decoder.sv
// iDMA instruction decoder on the cv32e40x X-interface with N_CH per-channel shadow descriptors.
// Optional 2D descriptor support (strides, repetitions) is enabled by defining IDMA_XIF_2D_EN.

module idma_xif_ch_regs #(
    parameter int ADDR_W = 32,
    parameter int TID_W  = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              src_we,
    input  logic              dst_we,
    input  logic              len_we,
    input  logic              str_we,
    input  logic              rep_we,
    input  logic              start_we,
    input  logic              dir_d,
    input  logic              tid_inc,
    input  logic [ADDR_W-1:0] wdata_a,
    input  logic [ADDR_W-1:0] wdata_b,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [ADDR_W-1:0] len,
    output logic [ADDR_W-1:0] src_stride,
    output logic [ADDR_W-1:0] dst_stride,
    output logic [ADDR_W-1:0] reps,
    output logic              dir,
    output logic [TID_W-1:0]  tid
);
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src <= '0;
            dst <= '0;
            len <= '0;
            dir <= 1'b0;
            tid <= '0;
        end else begin
            if (src_we)   src <= wdata_a;
            if (dst_we)   dst <= wdata_a;
            if (len_we)   len <= wdata_a;
            if (start_we) dir <= dir_d;
            if (tid_inc)  tid <= tid + 1'b1;
        end
    end

`ifdef IDMA_XIF_2D_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            src_stride <= '0;
            dst_stride <= '0;
            reps       <= ADDR_W'(1);
        end else begin
            if (str_we) begin
                src_stride <= wdata_a;
                dst_stride <= wdata_b;
            end
            if (rep_we) reps <= wdata_a;
        end
    end
`else
    logic unused_2d;
    assign unused_2d  = ^{str_we, rep_we, wdata_b};
    assign src_stride = '0;
    assign dst_stride = '0;
    assign reps       = ADDR_W'(1);
`endif
endmodule

module idma_xif_multich_decoder #(
    parameter int         N_CH   = 2,
    parameter int         ADDR_W = 32,
    parameter int         ID_W   = 4,
    parameter int         TID_W  = 8,
    parameter logic [6:0] OPCODE = 7'b1011011
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   x_issue_valid_i,
    output logic                   x_issue_ready_o,
    input  logic [31:0]            x_issue_instr_i,
    input  logic [ID_W-1:0]        x_issue_id_i,
    input  logic [63:0]            x_issue_rs_i,
    input  logic [1:0]             x_issue_rs_valid_i,
    output logic                   x_issue_accept_o,
    output logic                   x_issue_writeback_o,
    input  logic                   x_commit_valid_i,
    input  logic [ID_W-1:0]        x_commit_id_i,
    input  logic                   x_commit_kill_i,
    output logic                   x_result_valid_o,
    input  logic                   x_result_ready_i,
    output logic [ID_W-1:0]        x_result_id_o,
    output logic [4:0]             x_result_rd_o,
    output logic [31:0]            x_result_data_o,
    output logic                   x_result_we_o,
    output logic [N_CH-1:0]        req_valid_o,
    input  logic [N_CH-1:0]        req_ready_i,
    output logic [N_CH*ADDR_W-1:0] req_src_o,
    output logic [N_CH*ADDR_W-1:0] req_dst_o,
    output logic [N_CH*ADDR_W-1:0] req_len_o,
    output logic [N_CH-1:0]        req_dir_o,
    output logic [N_CH*ADDR_W-1:0] req_src_stride_o,
    output logic [N_CH*ADDR_W-1:0] req_dst_stride_o,
    output logic [N_CH*ADDR_W-1:0] req_reps_o,
    input  logic [N_CH-1:0]        busy_i
);
    localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WCOMMIT = 2'd1;
    localparam logic [1:0] S_LAUNCH  = 2'd2;
    localparam logic [1:0] S_RESULT  = 2'd3;

    localparam logic [2:0] F_SRC   = 3'd0;
    localparam logic [2:0] F_DST   = 3'd1;
    localparam logic [2:0] F_LEN   = 3'd2;
    localparam logic [2:0] F_STR   = 3'd3;
    localparam logic [2:0] F_REP   = 3'd4;
    localparam logic [2:0] F_START = 3'd5;
    localparam logic [2:0] F_STAT  = 3'd6;

    logic [1:0]        state_q;
    logic [2:0]        f3_q;
    logic [CH_W-1:0]   ch_q;
    logic              dir_q;
    logic [4:0]        rd_q;
    logic [ID_W-1:0]   id_q;
    logic [ADDR_W-1:0] rs1_q, rs2_q;
    logic [31:0]       res_q;

    logic [ADDR_W-1:0] len_a [N_CH];
    logic [TID_W-1:0]  tid_a [N_CH];

    logic [2:0] dec_f3;
    logic       dec_f3_ok, dec_ok, issue_hs, commit_match, commit_hit;

    assign dec_f3 = x_issue_instr_i[14:12];

    always_comb begin
        dec_f3_ok = 1'b0;
        case (dec_f3)
            F_SRC, F_DST, F_LEN, F_START, F_STAT: dec_f3_ok = 1'b1;
`ifdef IDMA_XIF_2D_EN
            F_STR, F_REP:                         dec_f3_ok = 1'b1;
`endif
            default:                              dec_f3_ok = 1'b0;
        endcase
    end

    // The range check uses the full 3-bit channel field so out-of-range encodings
    // are rejected instead of aliasing onto a lower channel.
    assign dec_ok = (x_issue_instr_i[6:0] == OPCODE) && dec_f3_ok &&
                    ({29'b0, x_issue_instr_i[27:25]} < 32'(N_CH));

    assign x_issue_ready_o     = (state_q == S_IDLE) && (&x_issue_rs_valid_i);
    assign issue_hs            = x_issue_valid_i && x_issue_ready_o;
    assign x_issue_accept_o    = issue_hs && dec_ok;
    assign x_issue_writeback_o = issue_hs && dec_ok && (dec_f3 == F_START || dec_f3 == F_STAT);

    assign commit_match = (state_q == S_WCOMMIT) && x_commit_valid_i && (x_commit_id_i == id_q);
    assign commit_hit   = commit_match && !x_commit_kill_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            f3_q    <= '0;
            ch_q    <= '0;
            dir_q   <= 1'b0;
            rd_q    <= '0;
            id_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            res_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (issue_hs && dec_ok) begin
                    f3_q    <= dec_f3;
                    ch_q    <= x_issue_instr_i[25 +: CH_W];
                    dir_q   <= x_issue_instr_i[31];
                    rd_q    <= x_issue_instr_i[11:7];
                    id_q    <= x_issue_id_i;
                    rs1_q   <= ADDR_W'(x_issue_rs_i[31:0]);
                    rs2_q   <= ADDR_W'(x_issue_rs_i[63:32]);
                    state_q <= S_WCOMMIT;
                end
                S_WCOMMIT: if (commit_match) begin
                    state_q <= S_IDLE;
                    if (!x_commit_kill_i) begin
                        if (f3_q == F_START) begin
                            if (len_a[ch_q] == '0) begin
                                res_q   <= '1;
                                state_q <= S_RESULT;
                            end else begin
                                state_q <= S_LAUNCH;
                            end
                        end else if (f3_q == F_STAT) begin
                            // req_valid_o is never high here: only one instruction is in flight
                            res_q   <= {31'b0, busy_i[ch_q]};
                            state_q <= S_RESULT;
                        end
                    end
                end
                S_LAUNCH: if (req_ready_i[ch_q]) begin
                    res_q   <= 32'(tid_a[ch_q]);
                    state_q <= S_RESULT;
                end
                S_RESULT: if (x_result_ready_i) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic sel;
        assign sel            = (ch_q == CH_W'(c));
        assign req_valid_o[c] = (state_q == S_LAUNCH) && sel;
        assign len_a[c]       = req_len_o[c*ADDR_W +: ADDR_W];

        idma_xif_ch_regs #(
            .ADDR_W(ADDR_W),
            .TID_W (TID_W)
        ) u_regs (
            .clk_i     (clk_i),
            .rst_ni    (rst_ni),
            .src_we    (commit_hit && sel && f3_q == F_SRC),
            .dst_we    (commit_hit && sel && f3_q == F_DST),
            .len_we    (commit_hit && sel && f3_q == F_LEN),
            .str_we    (commit_hit && sel && f3_q == F_STR),
            .rep_we    (commit_hit && sel && f3_q == F_REP),
            .start_we  (commit_hit && sel && f3_q == F_START),
            .dir_d     (dir_q),
            .tid_inc   (req_valid_o[c] && req_ready_i[c]),
            .wdata_a   (rs1_q),
            .wdata_b   (rs2_q),
            .src       (req_src_o[c*ADDR_W +: ADDR_W]),
            .dst       (req_dst_o[c*ADDR_W +: ADDR_W]),
            .len       (req_len_o[c*ADDR_W +: ADDR_W]),
            .src_stride(req_src_stride_o[c*ADDR_W +: ADDR_W]),
            .dst_stride(req_dst_stride_o[c*ADDR_W +: ADDR_W]),
            .reps      (req_reps_o[c*ADDR_W +: ADDR_W]),
            .dir       (req_dir_o[c]),
            .tid       (tid_a[c])
        );
    end

    assign x_result_valid_o = (state_q == S_RESULT);
    assign x_result_we_o    = x_result_valid_o;
    assign x_result_id_o    = x_result_valid_o ? id_q  : '0;
    assign x_result_rd_o    = x_result_valid_o ? rd_q  : '0;
    assign x_result_data_o  = x_result_valid_o ? res_q : '0;

    logic unused_instr;
    assign unused_instr = ^{x_issue_instr_i[24:15], x_issue_instr_i[30:28]};
endmodule

// File: tb/tb_idma_xif_multich_decoder.sv
// Self-checking bench for idma_xif_multich_decoder: directed plan steps plus randomized
// instruction streams checked against a descriptor/transfer-ID model.
module tb_idma_xif_multich_decoder;
    localparam int         N_CH   = 2;
    localparam int         ADDR_W = 32;
    localparam int         ID_W   = 4;
    localparam int         TID_W  = 2;
    localparam logic [6:0] OPC    = 7'b1011011;

    logic clk_i = 1'b0;
    logic rst_ni = 1'b1;
    logic x_issue_valid_i = 0, x_issue_ready_o;
    logic [31:0] x_issue_instr_i = '0;
    logic [ID_W-1:0] x_issue_id_i = '0;
    logic [63:0] x_issue_rs_i = '0;
    logic [1:0] x_issue_rs_valid_i = '0;
    logic x_issue_accept_o, x_issue_writeback_o;
    logic x_commit_valid_i = 0, x_commit_kill_i = 0;
    logic [ID_W-1:0] x_commit_id_i = '0;
    logic x_result_valid_o, x_result_ready_i = 0, x_result_we_o;
    logic [ID_W-1:0] x_result_id_o;
    logic [4:0] x_result_rd_o;
    logic [31:0] x_result_data_o;
    logic [N_CH-1:0] req_valid_o, req_ready_i = '0, req_dir_o, busy_i = '0;
    logic [N_CH*ADDR_W-1:0] req_src_o, req_dst_o, req_len_o;
    logic [N_CH*ADDR_W-1:0] req_src_stride_o, req_dst_stride_o, req_reps_o;

    idma_xif_multich_decoder #(
        .N_CH(N_CH), .ADDR_W(ADDR_W), .ID_W(ID_W), .TID_W(TID_W), .OPCODE(OPC)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .x_issue_valid_i(x_issue_valid_i), .x_issue_ready_o(x_issue_ready_o),
        .x_issue_instr_i(x_issue_instr_i), .x_issue_id_i(x_issue_id_i),
        .x_issue_rs_i(x_issue_rs_i), .x_issue_rs_valid_i(x_issue_rs_valid_i),
        .x_issue_accept_o(x_issue_accept_o), .x_issue_writeback_o(x_issue_writeback_o),
        .x_commit_valid_i(x_commit_valid_i), .x_commit_id_i(x_commit_id_i),
        .x_commit_kill_i(x_commit_kill_i),
        .x_result_valid_o(x_result_valid_o), .x_result_ready_i(x_result_ready_i),
        .x_result_id_o(x_result_id_o), .x_result_rd_o(x_result_rd_o),
        .x_result_data_o(x_result_data_o), .x_result_we_o(x_result_we_o),
        .req_valid_o(req_valid_o), .req_ready_i(req_ready_i),
        .req_src_o(req_src_o), .req_dst_o(req_dst_o), .req_len_o(req_len_o),
        .req_dir_o(req_dir_o), .req_src_stride_o(req_src_stride_o),
        .req_dst_stride_o(req_dst_stride_o), .req_reps_o(req_reps_o), .busy_i(busy_i)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    logic [ID_W-1:0] id_ctr = '0;

    // Reference model of the per-channel architectural state
    logic [31:0] m_src [N_CH], m_dst [N_CH], m_len [N_CH], m_ss [N_CH], m_ds [N_CH], m_rep [N_CH];
    logic        m_dir [N_CH];
    int          m_tid [N_CH];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sl(input logic [N_CH*ADDR_W-1:0] v, input int c);
        return v[c*ADDR_W +: ADDR_W];
    endfunction

    function automatic bit model_accept(input logic [31:0] instr);
        int f3, ch;
        bit is2d;
`ifdef IDMA_XIF_2D_EN
        is2d = 1;
`else
        is2d = 0;
`endif
        f3 = int'(instr[14:12]);
        ch = int'(instr[27:25]);
        return (instr[6:0] == OPC) && (ch < N_CH) && (f3 <= 6) && (is2d || (f3 != 3 && f3 != 4));
    endfunction

    task automatic model_reset();
        for (int c = 0; c < N_CH; c++) begin
            m_src[c] = 0; m_dst[c] = 0; m_len[c] = 0; m_ss[c] = 0; m_ds[c] = 0;
            m_rep[c] = 1; m_dir[c] = 0; m_tid[c] = 0;
        end
    endtask

    task automatic check_desc();
        for (int c = 0; c < N_CH; c++) begin
            chk($sformatf("src%0d", c), sl(req_src_o, c), m_src[c]);
            chk($sformatf("dst%0d", c), sl(req_dst_o, c), m_dst[c]);
            chk($sformatf("len%0d", c), sl(req_len_o, c), m_len[c]);
            chk($sformatf("sstr%0d", c), sl(req_src_stride_o, c), m_ss[c]);
            chk($sformatf("dstr%0d", c), sl(req_dst_stride_o, c), m_ds[c]);
            chk($sformatf("reps%0d", c), sl(req_reps_o, c), m_rep[c]);
            chk($sformatf("dir%0d", c), req_dir_o[c], m_dir[c]);
        end
    endtask

    task automatic do_issue(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2,
                            input logic [ID_W-1:0] id, output bit ok);
        int n;
        bit wb;
        ok = model_accept(instr);
        wb = ok && (instr[14:12] == 3'd5 || instr[14:12] == 3'd6);
        x_issue_instr_i = instr; x_issue_rs_i = {rs2, rs1}; x_issue_id_i = id;
        x_issue_rs_valid_i = 2'b11; x_issue_valid_i = 1'b1;
        #1;
        n = 0;
        while (!x_issue_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
        chk("issue_ready", x_issue_ready_o, 1);
        chk("accept", x_issue_accept_o, ok);
        chk("writeback", x_issue_writeback_o, wb);
        @(posedge clk_i); #1;
        x_issue_valid_i = 1'b0;
    endtask

    task automatic do_commit(input logic [ID_W-1:0] id, input bit kill, input bit wrong);
        if (wrong) begin
            x_commit_valid_i = 1; x_commit_id_i = id + 1'b1; x_commit_kill_i = 1;
            @(posedge clk_i); #1;
            chk("wrong_id_wait", x_issue_ready_o, 0);
            chk("wrong_id_noreq", req_valid_o, 0);
            chk("wrong_id_nores", x_result_valid_o, 0);
        end
        x_commit_valid_i = 1; x_commit_id_i = id; x_commit_kill_i = kill;
        @(posedge clk_i); #1;
        x_commit_valid_i = 0; x_commit_kill_i = 0;
    endtask

    task automatic do_launch(input int ch, input int bp);
        logic [N_CH-1:0] mask;
        mask = N_CH'(1 << ch);
        chk("req_valid", req_valid_o, mask);
        check_desc();
        for (int i = 0; i < bp; i++) begin
            req_ready_i = ~mask;
            @(posedge clk_i); #1;
            chk("req_hold", req_valid_o, mask);
            chk("req_src_hold", sl(req_src_o, ch), m_src[ch]);
            chk("req_busy_ready", x_issue_ready_o, 0);
            chk("req_no_res", x_result_valid_o, 0);
        end
        req_ready_i = mask;
        @(posedge clk_i); #1;
        req_ready_i = '0;
    endtask

    task automatic do_result(input logic [31:0] exp, input logic [4:0] rd, input logic [ID_W-1:0] id,
                             input int bp);
        chk("res_valid", x_result_valid_o, 1);
        chk("res_we", x_result_we_o, 1);
        chk("res_data", x_result_data_o, exp);
        chk("res_rd", x_result_rd_o, rd);
        chk("res_id", x_result_id_o, id);
        chk("res_noreq", req_valid_o, 0);
        for (int i = 0; i < bp; i++) begin
            @(posedge clk_i); #1;
            chk("res_hold_v", x_result_valid_o, 1);
            chk("res_hold_d", x_result_data_o, exp);
            chk("res_hold_id", x_result_id_o, id);
            chk("res_busy_ready", x_issue_ready_o, 0);
        end
        x_result_ready_i = 1;
        @(posedge clk_i); #1;
        x_result_ready_i = 0;
        chk("res_done", x_result_valid_o, 0);
        chk("res_idle", x_issue_ready_o, 1);
    endtask

    task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input int ch, input bit dir,
                             input logic [31:0] rs1, input logic [31:0] rs2, input bit kill,
                             input bit wrong, input int req_bp, input int res_bp);
        logic [31:0] instr, exp_data;
        logic [4:0] rd;
        logic [ID_W-1:0] id;
        logic [2:0] chv;
        bit ok, has_res;
        chv = 3'(ch);
        rd = 5'($urandom_range(1, 31));
        id = id_ctr; id_ctr = id_ctr + 1'b1;
        instr = {dir, 3'b000, chv, 10'b0, f3, rd, opc};
        do_issue(instr, rs1, rs2, id, ok);
        if (!ok) begin
            chk("rej_idle", x_issue_ready_o, 1);
            check_desc();
            return;
        end
        do_commit(id, kill, wrong);
        if (kill) begin
            chk("kill_idle", x_issue_ready_o, 1);
            check_desc();
            return;
        end
        has_res = 0;
        exp_data = '0;
        case (f3)
            3'd0: m_src[ch] = rs1;
            3'd1: m_dst[ch] = rs1;
            3'd2: m_len[ch] = rs1;
            3'd3: begin m_ss[ch] = rs1; m_ds[ch] = rs2; end
            3'd4: m_rep[ch] = rs1;
            3'd5: begin
                m_dir[ch] = dir;
                has_res = 1;
                if (m_len[ch] == 0) begin
                    exp_data = 32'hFFFF_FFFF;
                    chk("zlen_noreq", req_valid_o, 0);
                end else begin
                    do_launch(ch, req_bp);
                    exp_data = 32'(m_tid[ch]);
                    m_tid[ch] = (m_tid[ch] + 1) % (1 << TID_W);
                end
            end
            3'd6: begin has_res = 1; exp_data = {31'b0, busy_i[ch]}; end
            default: ;
        endcase
        if (has_res) do_result(exp_data, rd, id, res_bp);
        else chk("cfg_idle", x_issue_ready_o, 1);
        check_desc();
    endtask

    initial begin
        logic [ID_W-1:0] rid;
        bit ok;
        model_reset();
        #2 rst_ni = 0;
        #10;
        chk("rst_ready", x_issue_ready_o, 0);
        chk("rst_accept", x_issue_accept_o, 0);
        chk("rst_reqv", req_valid_o, 0);
        chk("rst_resv", x_result_valid_o, 0);
        chk("rst_resd", x_result_data_o, 0);
        check_desc();
        @(posedge clk_i); #1 rst_ni = 1;

        // Channel 1 transfer with request and result backpressure
        run_instr(OPC, 3'd0, 1, 0, 32'h1000_0000, 0, 0, 0, 0, 0);
        run_instr(OPC, 3'd1, 1, 0, 32'h0000_0400, 0, 0, 1, 0, 0);
        run_instr(OPC, 3'd2, 1, 0, 32'h0000_0100, 0, 0, 0, 0, 0);
        run_instr(OPC, 3'd5, 1, 1, 0, 0, 0, 0, 10, 5);
        run_instr(OPC, 3'd5, 1, 1, 0, 0, 0, 0, 0, 0);
        // Killed commit, then invalid encodings
        run_instr(OPC, 3'd0, 0, 0, 32'h0000_DEAD, 0, 1, 0, 0, 0);
        run_instr(OPC, 3'd0, 3, 0, 32'h1234_5678, 0, 0, 0, 0, 0);
        run_instr(OPC, 3'd7, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0);
        run_instr(7'h2B, 3'd0, 0, 0, 32'h1234_5678, 0, 0, 0, 0, 0);
        // Transfer-ID wrap and zero-length start
        run_instr(OPC, 3'd5, 1, 0, 0, 0, 0, 0, 1, 0);
        run_instr(OPC, 3'd5, 1, 1, 0, 0, 0, 0, 0, 1);
        run_instr(OPC, 3'd5, 1, 0, 0, 0, 0, 0, 2, 0);
        run_instr(OPC, 3'd5, 0, 1, 0, 0, 0, 0, 0, 0);
        // 2D descriptor (rejected when the feature is compiled out)
        run_instr(OPC, 3'd3, 0, 0, 32'h40, 32'h80, 0, 0, 0, 0);
        run_instr(OPC, 3'd4, 0, 0, 32'h4, 0, 0, 0, 0, 0);
        // Status
        busy_i = 2'b10;
        run_instr(OPC, 3'd6, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(OPC, 3'd6, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 80; i++) begin
            logic [2:0] f3;
            logic [31:0] rs1;
            int ch;
            busy_i = N_CH'($urandom);
            f3 = 3'($urandom_range(0, 7));
            ch = ($urandom_range(0, 5) == 0) ? $urandom_range(2, 7) : $urandom_range(0, N_CH - 1);
            rs1 = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
            run_instr(($urandom_range(0, 9) == 0) ? 7'h2B : OPC, f3, ch, 1'($urandom),
                      rs1, $urandom, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while a request is pending
        run_instr(OPC, 3'd2, 1, 0, 32'h80, 0, 0, 0, 0, 0);
        rid = id_ctr; id_ctr = id_ctr + 1'b1;
        do_issue({1'b1, 3'b000, 3'd1, 10'b0, 3'd5, 5'd9, OPC}, 0, 0, rid, ok);
        do_commit(rid, 0, 0);
        chk("launch_pending", req_valid_o, 2'b10);
        x_issue_rs_valid_i = 2'b00;
        rst_ni = 0;
        #1;
        model_reset();
        chk("mid_rst_reqv", req_valid_o, 0);
        chk("mid_rst_resv", x_result_valid_o, 0);
        chk("mid_rst_ready", x_issue_ready_o, 0);
        check_desc();
        @(posedge clk_i); #1 rst_ni = 1;
        run_instr(OPC, 3'd5, 1, 0, 0, 0, 0, 0, 0, 0);
        run_instr(OPC, 3'd2, 1, 0, 32'h10, 0, 0, 0, 0, 0);
        run_instr(OPC, 3'd5, 1, 0, 0, 0, 0, 0, 1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
